// File: rtl/pc_sequencer_if.sv
// Program-memory fetch handshake between pc_sequencer (master) and
// the instruction memory (slave).
interface pc_sequencer_if;
  logic        fetch_req;
  logic        mem_ready;
  logic [15:0] instr;

  modport master (output fetch_req, input mem_ready, input instr);
  modport slave  (input fetch_req, output mem_ready, output instr);
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/issue controller for the program counter block.
// Fetches one instruction word per handshake, decodes control flow and
// drives the counter's preload/jsr strobes, keeping its own return stack.
// Optional build macro PC_SEQ_STATS_EN adds the instr_count output.
module pc_sequencer #(
  parameter int ADDR_W      = 11,
  parameter int REL_W       = 10,
  parameter int STACK_DEPTH = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [ADDR_W-1:0]                start_addr,
  input  logic [ADDR_W-1:0]                pc_in,
  pc_sequencer_if.master                   mem,
  output logic                             pc_step,
  output logic                             preload,
  output logic [ADDR_W-1:0]                preload_addr,
  output logic [REL_W-1:0]                 relative_addr,
  output logic                             jsr,
  output logic                             ret,
  output logic                             halted,
  output logic                             fault,
  output logic [$clog2(STACK_DEPTH+1)-1:0] depth
`ifdef PC_SEQ_STATS_EN
  ,
  output logic [15:0]                      instr_count
`endif
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int PTR_W   = $clog2(STACK_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_FETCH,
    S_ISSUE,
    S_HALT,
    S_FAULT
  } state_t;

  state_t             state_reg, state_next;
  logic [15:0]        instr_reg;
  logic [ADDR_W-1:0]  start_addr_reg;
  logic [ADDR_W-1:0]  top_reg;
  logic [DEPTH_W-1:0] depth_reg;
  logic [ADDR_W-1:0]  stack_mem [STACK_DEPTH];
  logic [PTR_W-1:0]   top_idx;
  logic [PTR_W-1:0]   push_idx;
  logic               load_start;
  logic               latch_instr;
  logic               push;
  logic               pop;
  logic               call_ok;
  logic               ret_ok;
  logic [1:0]         op;
  logic               is_halt;
  logic               unused_instr_bits;

  assign op       = instr_reg[15:14];
  assign is_halt  = instr_reg[13];
  assign top_idx  = PTR_W'(depth_reg - DEPTH_W'(1));
  assign push_idx = PTR_W'(depth_reg);
  assign call_ok  = (depth_reg != DEPTH_W'(STACK_DEPTH));
  assign ret_ok   = (depth_reg != '0);
  assign ret      = 1'b0;
  assign depth    = depth_reg;
  // Bits between the JMP target and the HALT flag carry no meaning here.
  assign unused_instr_bits = &{1'b0, instr_reg[12:ADDR_W]};

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and strobe decode; every select is qualified by pc_step.
  always_comb begin
    state_next    = state_reg;
    pc_step       = 1'b0;
    preload       = 1'b0;
    preload_addr  = '0;
    relative_addr = '0;
    jsr           = 1'b0;
    halted        = 1'b0;
    fault         = 1'b0;
    mem.fetch_req = 1'b0;
    load_start    = 1'b0;
    latch_instr   = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          load_start = 1'b1;
          state_next = S_START;
        end
      end
      S_START: begin
        pc_step      = 1'b1;
        preload      = 1'b1;
        preload_addr = start_addr_reg;
        state_next   = S_FETCH;
      end
      S_FETCH: begin
        mem.fetch_req = 1'b1;
        if (mem.mem_ready) begin
          latch_instr = 1'b1;
          state_next  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_next = S_FETCH;
        case (op)
          2'b00: pc_step = 1'b1;
          2'b01: begin
            if (call_ok) begin
              pc_step       = 1'b1;
              jsr           = 1'b1;
              relative_addr = instr_reg[REL_W-1:0];
              push          = 1'b1;
            end else begin
              state_next = S_FAULT;
            end
          end
          2'b10: begin
            if (ret_ok) begin
              pc_step      = 1'b1;
              preload      = 1'b1;
              preload_addr = top_reg + ADDR_W'(1);
              pop          = 1'b1;
            end else begin
              state_next = S_FAULT;
            end
          end
          default: begin
            if (is_halt) begin
              state_next = S_HALT;
            end else begin
              pc_step      = 1'b1;
              preload      = 1'b1;
              preload_addr = instr_reg[ADDR_W-1:0];
            end
          end
        endcase
      end
      S_HALT: begin
        halted = 1'b1;
        if (start) begin
          load_start = 1'b1;
          state_next = S_START;
        end
      end
      S_FAULT: begin
        fault = 1'b1;
        if (start) begin
          load_start = 1'b1;
          state_next = S_START;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Entry address, stack occupancy and the fetched word.
  always_ff @(posedge clock) begin
    if (reset) begin
      start_addr_reg <= '0;
      depth_reg      <= '0;
      instr_reg      <= '0;
    end else begin
      if (load_start) begin
        start_addr_reg <= start_addr;
        depth_reg      <= '0;
      end else if (push) begin
        depth_reg <= depth_reg + DEPTH_W'(1);
      end else if (pop) begin
        depth_reg <= depth_reg - DEPTH_W'(1);
      end
      if (latch_instr) begin
        instr_reg <= mem.instr;
      end
    end
  end

  // Return stack storage; the top entry is read during FETCH so it is
  // already registered when a RET reaches ISSUE.
  always_ff @(posedge clock) begin
    if (push) begin
      stack_mem[push_idx] <= pc_in;
    end
    if (state_reg == S_FETCH) begin
      top_reg <= stack_mem[top_idx];
    end
  end

`ifdef PC_SEQ_STATS_EN
  logic [15:0] count_reg;

  // Saturating count of issued instructions since the last start.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load_start) begin
      count_reg <= '0;
    end else if ((state_reg == S_ISSUE) && pc_step && (count_reg != 16'hFFFF)) begin
      count_reg <= count_reg + 16'd1;
    end
  end

  assign instr_count = count_reg;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a counter + program memory environment, an
// instruction-level reference model checked every cycle, directed
// scenarios with literal expectations, then randomized programs.
module tb_pc_sequencer;
  localparam int D = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;

  logic        clock;
  logic        reset;
  logic        start;
  logic [10:0] start_addr;
  logic [10:0] pc_reg;
  logic        pc_step, preload, jsr, ret, halted, fault;
  logic [10:0] preload_addr;
  logic [9:0]  relative_addr;
  logic [2:0]  depth;
`ifdef PC_SEQ_STATS_EN
  logic [15:0] instr_count;
`endif
  logic [15:0] prog [0:2047];

  pc_sequencer_if mem_if ();

  pc_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .start_addr    (start_addr),
    .pc_in         (pc_reg),
    .mem           (mem_if),
    .pc_step       (pc_step),
    .preload       (preload),
    .preload_addr  (preload_addr),
    .relative_addr (relative_addr),
    .jsr           (jsr),
    .ret           (ret),
    .halted        (halted),
    .fault         (fault),
    .depth         (depth)
`ifdef PC_SEQ_STATS_EN
    ,
    .instr_count   (instr_count)
`endif
  );

  int assert_count = 0;
  int fail_count   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    assert_count++;
    if (act !== exp) begin
      fail_count++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Counter environment: moves only on pc_step cycles.
  initial pc_reg = '0;
  always @(posedge clock) begin
    if (pc_step) begin
      if (preload)  pc_reg <= preload_addr;
      else if (jsr) pc_reg <= pc_reg + 11'(relative_addr);
      else          pc_reg <= pc_reg + 11'd1;
    end
  end

  assign mem_if.instr = prog[pc_reg];

  // Reference model state (instruction level).
  int          m_mode = M_IDLE;
  bit          armed = 0, exp_start = 0, exp_issue = 0, prev_step = 0;
  logic [15:0] iss_word;
  logic [10:0] iss_pc;
  logic [10:0] m_start_addr;
  logic [10:0] m_stack [$];
  logic [10:0] preload_log [$];
  logic [3:0]  depth_log [$];
  int          step_count = 0;

  // Compare process: checks outputs against the model, then advances it.
  always @(negedge clock) begin
    bit this_fetch, quiet, e_step, e_pre, e_jsr;
    logic [10:0] e_addr;
    this_fetch = (m_mode == M_RUN) && !exp_start && !exp_issue;
    quiet      = (m_mode != M_RUN) && !exp_start && !exp_issue;
    if (armed) begin
      check("ret_zero", ret, 0);
      if (!pc_step) check("select_qualified", {preload, jsr}, 0);
      check("step_spacing", prev_step & pc_step, 0);
      check("depth", depth, m_stack.size());
`ifdef PC_SEQ_STATS_EN
      check("instr_count", instr_count, (step_count > 65535) ? 65535 : step_count);
`endif
      if (exp_start) begin
        check("start_ctl", {pc_step, preload, jsr, mem_if.fetch_req, halted, fault}, 6'b110000);
        check("start_addr", preload_addr, m_start_addr);
        if (pc_step && preload) preload_log.push_back(preload_addr);
      end else if (exp_issue) begin
        e_step = 0; e_pre = 0; e_jsr = 0; e_addr = '0;
        case (iss_word[15:14])
          2'b00: e_step = 1;
          2'b01: if (m_stack.size() < D) begin e_step = 1; e_jsr = 1; end
                 else m_mode = M_FAULT;
          2'b10: if (m_stack.size() > 0) begin e_step = 1; e_pre = 1; e_addr = m_stack[$] + 11'd1; end
                 else m_mode = M_FAULT;
          default: if (iss_word[13]) m_mode = M_HALT;
                   else begin e_step = 1; e_pre = 1; e_addr = iss_word[10:0]; end
        endcase
        check("issue_ctl", {pc_step, preload, jsr, mem_if.fetch_req, halted, fault},
              {e_step, e_pre, e_jsr, 3'b000});
        if (e_pre) check("issue_preload_addr", preload_addr, e_addr);
        if (e_jsr) check("issue_rel", relative_addr, iss_word[9:0]);
        if (e_jsr) begin
          m_stack.push_back(iss_pc);
          depth_log.push_back(4'(m_stack.size()));
        end
        if (e_pre && iss_word[15:14] == 2'b10) begin
          void'(m_stack.pop_back());
          depth_log.push_back(4'(m_stack.size()));
        end
        if (pc_step) step_count++;
        if (pc_step && preload) preload_log.push_back(preload_addr);
        $display("issue pc=%03h word=%04h step=%0d preload=%0d jsr=%0d depth=%0d",
                 iss_pc, iss_word, pc_step, preload, jsr, m_stack.size());
      end else begin
        check("quiet_step", pc_step, 0);
        check("fetch_req", mem_if.fetch_req, m_mode == M_RUN);
        check("flags", {halted, fault}, {m_mode == M_HALT, m_mode == M_FAULT});
        if (m_mode != M_RUN) check("idle_bus", {preload_addr, relative_addr}, 0);
      end
      prev_step = pc_step;
    end
    if (reset) begin
      armed = 1; m_mode = M_IDLE; m_stack.delete();
      exp_start = 0; exp_issue = 0; step_count = 0;
    end else if (armed) begin
      exp_start = quiet && start;
      exp_issue = this_fetch && mem_if.mem_ready;
      if (exp_issue) begin
        iss_word = mem_if.instr;
        iss_pc   = pc_reg;
      end
      if (exp_start) begin
        m_mode = M_RUN; m_stack.delete(); m_start_addr = start_addr;
        step_count = 0; preload_log.delete(); depth_log.delete();
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(input logic [10:0] addr);
    start = 1'b1;
    start_addr = addr;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_stop();
    for (int i = 0; i < 300; i++) begin
      if (halted || fault) break;
      tick();
    end
    check("stop_reached", halted | fault, 1);
  endtask

  function automatic logic [15:0] rand_word();
    int r = $urandom_range(0, 99);
    logic [15:0] w = 16'($urandom);
    if (r < 40)      w[15:14] = 2'b00;
    else if (r < 60) w[15:14] = 2'b01;
    else if (r < 78) w[15:14] = 2'b10;
    else if (r < 95) w[15:13] = 3'b110;
    else             w[15:13] = 3'b111;
    return w;
  endfunction

  initial begin
    bit found;
    int fetch_cycles;
    reset = 1'b1; start = 1'b0; start_addr = '0; mem_if.mem_ready = 1'b0;
    for (int i = 0; i < 2048; i++) prog[i] = 16'hE000;
    repeat (3) tick();
    reset = 1'b0;
    check("reset_state", {mem_if.fetch_req, pc_step, preload, preload_addr, relative_addr,
                          jsr, ret, halted, fault, depth}, 0);

    // Three sequential words then HALT.
    prog[11'h010] = 16'h0000; prog[11'h011] = 16'h0000; prog[11'h012] = 16'h0000;
    mem_if.mem_ready = 1'b1;
    pulse_start(11'h010);
    check("A_start_preload", {pc_step, preload, preload_addr}, {2'b11, 11'h010});
    wait_stop();
    check("A_halted", {halted, fault, mem_if.fetch_req}, 3'b100);
    check("A_steps", step_count, 3);

    // Nested calls and returns, restarted from HALT.
    prog[11'h020] = 16'h4005; prog[11'h025] = 16'h4003;
    prog[11'h028] = 16'h8000; prog[11'h026] = 16'h8000;
    pulse_start(11'h020);
    wait_stop();
    check("B_halted", halted, 1);
    check("B_preload_count", preload_log.size(), 3);
    if (preload_log.size() == 3)
      check("B_preload_seq", {preload_log[0], preload_log[1], preload_log[2]},
            {11'h020, 11'h026, 11'h021});
    check("B_depth_count", depth_log.size(), 4);
    if (depth_log.size() == 4)
      check("B_depth_seq", {depth_log[0], depth_log[1], depth_log[2], depth_log[3]}, 16'h1210);

    // Overflow: five CALLs into a four-entry stack.
    for (int a = 'h100; a <= 'h104; a++) prog[a] = 16'h4001;
    pulse_start(11'h100);
    wait_stop();
    check("C_overflow", {fault, halted, depth}, {2'b10, 3'd4});
    check("C_steps", step_count, 4);

    // Restart from FAULT, then underflow.
    prog[11'h200] = 16'h8000;
    pulse_start(11'h200);
    check("C_restart", {fault, depth, pc_step, preload, preload_addr}, {1'b0, 3'd0, 2'b11, 11'h200});
    wait_stop();
    check("C_underflow", {fault, pc_step}, 2'b10);
    check("C_underflow_steps", step_count, 0);

    // Memory wait, JMP to 0x7FF, wrap-around return, reset mid-FETCH.
    reset = 1'b1; tick(); reset = 1'b0;
    mem_if.mem_ready = 1'b0;
    prog[11'h300] = 16'hC7FF; prog[11'h7FF] = 16'h4001; prog[11'h000] = 16'h8000;
    pulse_start(11'h300);
    fetch_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (mem_if.fetch_req && !pc_step) fetch_cycles++;
      mem_if.mem_ready = (i == 7);
    end
    check("D_fetch_hold", fetch_cycles, 8);
    tick();
    check("D_jmp", {pc_step, preload, preload_addr, mem_if.fetch_req}, {2'b11, 11'h7FF, 1'b0});
    found = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pc_step && preload) begin found = 1; break; end
    end
    check("D_ret_seen", found, 1);
    check("D_ret_wrap", preload_addr, 11'h000);
    mem_if.mem_ready = 1'b0;
    tick();
    tick();
    check("D_midfetch", {mem_if.fetch_req, pc_step}, 2'b10);
    check("D_preload_seq_count", preload_log.size(), 3);
    if (preload_log.size() == 3)
      check("D_preload_seq", {preload_log[0], preload_log[1], preload_log[2]},
            {11'h300, 11'h7FF, 11'h000});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("D_reset_out", {mem_if.fetch_req, pc_step, preload, preload_addr, relative_addr,
                          jsr, ret, halted, fault, depth}, 0);

    // Randomized programs, handshake timing, start pulses and resets.
    for (int c = 0; c < 4000; c++) begin
      if (c % 1000 == 0)
        for (int i = 0; i < 2048; i++) prog[i] = rand_word();
      mem_if.mem_ready = ($urandom_range(0, 9) < 7);
      start      = ($urandom_range(0, 19) == 0);
      start_addr = 11'($urandom);
      reset      = ($urandom_range(0, 299) == 0);
      tick();
    end
    start = 1'b0; reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end
endmodule
